// File: rtl/gon_row_collector_if.sv
// Bundle between one row collector and its surroundings: config, the shared
// row tag/response bus, the Y-level output stream and status.
interface gon_row_collector_if #(
  parameter int ID_LEN    = 4,
  parameter int VALUE_LEN = 32,
  parameter int NUM_COL   = 8
);
  logic                         cfg_start;
  logic [ID_LEN-1:0]            cfg_tag_base;
  logic [ID_LEN:0]              cfg_count;
  logic [ID_LEN-1:0]            tag;
  logic                         ready_out;
  logic [NUM_COL-1:0]           col_enable;
  logic [NUM_COL*VALUE_LEN-1:0] col_value;
  logic                         out_valid;
  logic                         out_ready;
  logic [ID_LEN-1:0]            out_tag;
  logic [VALUE_LEN-1:0]         out_data;
  logic                         busy;
  logic                         done;
  logic                         collision;

  // master: the collector itself
  modport master (
    input  cfg_start, cfg_tag_base, cfg_count, col_enable, col_value, out_ready,
    output tag, ready_out, out_valid, out_tag, out_data, busy, done, collision
  );

  // slave: X controllers, Y network and config agent seen as one
  modport slave (
    output cfg_start, cfg_tag_base, cfg_count, col_enable, col_value, out_ready,
    input  tag, ready_out, out_valid, out_tag, out_data, busy, done, collision
  );
endinterface

// File: rtl/gon_row_collector.sv
// Row collector for GON X multicast controllers: walks a tag sequence, captures
// the single wired-OR response per tag and streams {tag, value} out via a small FIFO.
module gon_row_collector #(
  parameter int ID_LEN     = 4,
  parameter int VALUE_LEN  = 32,
  parameter int NUM_COL    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  gon_row_collector_if.master  bus
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, FLUSH = 2'd2} state_t;
  typedef struct packed {
    logic [ID_LEN-1:0]    tag;
    logic [VALUE_LEN-1:0] value;
  } entry_t;

  state_t               state_q, state_d;
  logic [ID_LEN-1:0]    tag_q;
  logic [ID_LEN:0]      rem_q;
  logic                 done_q, done_d, coll_q;
  entry_t               mem [FIFO_DEPTH];
  logic [PW-1:0]        rd_ptr, wr_ptr;
  logic [PW:0]          cnt_q;
  logic                 full, empty, push, pop, ready;
  logic                 start_go, start_nil, multi_hit;
  logic [VALUE_LEN-1:0] row_or;
  entry_t               head;

  assign full      = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign empty     = (cnt_q == '0);
  assign start_go  = bus.cfg_start && (bus.cfg_count != '0);
  assign start_nil = bus.cfg_start && (bus.cfg_count == '0);

  // Idle columns drive zero, so OR-ing every column yields the responder's value.
  always_comb begin
    row_or = '0;
    for (int c = 0; c < NUM_COL; c++)
      row_or = row_or | bus.col_value[c*VALUE_LEN +: VALUE_LEN];
  end

  // More than one bit set: clearing the lowest set bit leaves something behind.
  assign multi_hit = |(bus.col_enable & (bus.col_enable - NUM_COL'(1)));

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_go) state_d = SCAN;
      SCAN:    if (push && rem_q == (ID_LEN+1)'(1)) state_d = FLUSH;
      FLUSH:   if (empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. ready uses the registered full flag only, so a pop frees
  // the slot for the row one cycle later.
  always_comb begin
    ready  = 1'b0;
    done_d = 1'b0;
    unique case (state_q)
      IDLE:    done_d = start_nil;
      SCAN:    ready  = ~full;
      FLUSH:   done_d = empty;
      default: ;
    endcase
  end

  assign push = ready & (|bus.col_enable);
  assign pop  = ~empty & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q  <= '0;
      rem_q  <= '0;
      done_q <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      done_q <= done_d;
      if (multi_hit) coll_q <= 1'b1;
      if (state_q == IDLE && start_go) begin
        tag_q <= bus.cfg_tag_base;
        rem_q <= bus.cfg_count;
      end else if (push) begin
        tag_q <= tag_q + ID_LEN'(1);
        rem_q <= rem_q - (ID_LEN+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {tag_q, row_or};
  end

  assign head          = empty ? '0 : mem[rd_ptr];
  assign bus.out_valid = ~empty;
  assign bus.out_tag   = head.tag;
  assign bus.out_data  = head.value;
  assign bus.tag       = tag_q;
  assign bus.ready_out = ready;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.collision = coll_q;

  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_cnt_bound:    assert property (@(posedge clk) disable iff (rst) cnt_q <= (PW+1)'(FIFO_DEPTH));
  a_head_hold:    assert property (@(posedge clk) disable iff (rst)
                    (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(head)));
endmodule
